watch_set_ctrl: RTL and testbench

- Turns debounced front-panel buttons into the set-mode control strobes consumed by the watch digit counters.
- Outputs: one-hot field enable, single-cycle inc/dec/clear pulses, a mode flag and a blink signal for the display driver.
- Sits between the button debouncers and the counter chain. It is the driving end of the counters' en/inc/dec/clear interface.

---
 rtl/watch_pkg.sv | 32 +++
 rtl/btn_edge_detect.sv | 18 +
 rtl/watch_set_ctrl.sv | 168 ++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared types and constants for the watch set-mode controller
package watch_pkg;

  typedef enum logic [1:0] {
    RUN,
    SET_IDLE,
    SET_DELAY,
    SET_REPEAT
  } state_t;

  localparam int FIELD_HOUR = 3;
  localparam int FIELD_MIN  = 2;
  localparam int FIELD_SEC  = 1;
  localparam int FIELD_MSEC = 0;

  localparam int GUARD_CYCLES = 2;

  // bit positions of the buttons in the packed button vector
  localparam int BTN_D    = 0;
  localparam int BTN_U    = 1;
  localparam int BTN_L    = 2;
  localparam int BTN_NEXT = 3;
  localparam int BTN_MODE = 4;
  localparam int NUM_BTNS = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - one-register rising-edge detector for a debounced button
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - set-mode FSM driving the digit counters' en/inc/dec/clear strobes
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int NUM_FIELDS   = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int BLINK_TICKS  = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_l,
  input  logic                  btn_u,
  input  logic                  btn_d,
  output logic                  o_set_mode,
  output logic [NUM_FIELDS-1:0] o_en,
  output logic                  o_inc,
  output logic                  o_dec,
  output logic                  o_clear,
  output logic                  o_blink
);

  localparam int CNT_MAX = max3(REPEAT_DELAY, REPEAT_RATE, BLINK_TICKS);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SAT_V   = CW'(CNT_MAX);
  localparam logic [CW-1:0] DELAY_V = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_V  = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] BLINK_V = CW'(BLINK_TICKS);
  localparam logic [NUM_FIELDS-1:0] EN_TOP = {1'b1, {(NUM_FIELDS-1){1'b0}}};

  logic [NUM_BTNS-1:0] btn_lvl, rise;
  assign btn_lvl = {btn_mode, btn_next, btn_l, btn_u, btn_d};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_edge
    btn_edge_detect u_edge (.clk(clk), .rst(rst), .level(btn_lvl[i]), .rise(rise[i]));
  end

  state_t                state_q, state_n;
  logic [NUM_FIELDS-1:0] en_q, en_n;
  logic                  inc_q, inc_n, dec_q, dec_n, clr_q, clr_n;
  logic                  blink_q, blink_n;
  logic                  held_dn_q, held_dn_n;
  logic [1:0]            guard_q, guard_n;
  logic [CW-1:0]         rep_q, rep_n, blk_q, blk_n;
  logic [CW-1:0]         rep_inc, blk_inc, rep_target;
  logic                  held_lvl;

  assign rep_inc    = (rep_q == SAT_V) ? rep_q : rep_q + 1'b1;
  assign blk_inc    = (blk_q == SAT_V) ? blk_q : blk_q + 1'b1;
  assign rep_target = (state_q == SET_DELAY) ? DELAY_V : RATE_V;
  assign held_lvl   = held_dn_q ? btn_d : btn_u;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      en_q      <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      clr_q     <= 1'b0;
      blink_q   <= 1'b1;
      held_dn_q <= 1'b0;
      guard_q   <= '0;
      rep_q     <= '0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_n;
      en_q      <= en_n;
      inc_q     <= inc_n;
      dec_q     <= dec_n;
      clr_q     <= clr_n;
      blink_q   <= blink_n;
      held_dn_q <= held_dn_n;
      guard_q   <= guard_n;
      rep_q     <= rep_n;
      blk_q     <= blk_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    en_n      = en_q;
    inc_n     = 1'b0;
    dec_n     = 1'b0;
    clr_n     = 1'b0;
    blink_n   = blink_q;
    held_dn_n = held_dn_q;
    guard_n   = guard_q;
    rep_n     = rep_q;
    blk_n     = blk_q;
    if (state_q == RUN) begin
      en_n    = '0;
      blink_n = 1'b1;
      guard_n = '0;
      rep_n   = '0;
      blk_n   = '0;
      if (rise[BTN_MODE]) begin
        state_n = SET_IDLE;
        en_n    = EN_TOP;
        guard_n = 2'(GUARD_CYCLES);
      end
    end else begin
      if (i_tick) begin
        if (blk_inc == BLINK_V) begin
          blink_n = ~blink_q;
          blk_n   = '0;
        end else begin
          blk_n = blk_inc;
        end
      end
      if (rise[BTN_MODE]) begin
        state_n = RUN;
        en_n    = '0;
        blink_n = 1'b1;
        guard_n = '0;
        rep_n   = '0;
        blk_n   = '0;
      end else if (rise[BTN_NEXT]) begin
        // a field change also cancels any hold in progress
        state_n = SET_IDLE;
        en_n    = {en_q[0], en_q[NUM_FIELDS-1:1]};
        guard_n = 2'(GUARD_CYCLES);
        rep_n   = '0;
      end else if (guard_q != '0) begin
        guard_n = guard_q - 1'b1;
      end else if (state_q == SET_IDLE) begin
        if (rise[BTN_L]) begin
          clr_n = 1'b1;
        end else if (rise[BTN_U] && !btn_d) begin
          inc_n     = 1'b1;
          held_dn_n = 1'b0;
          rep_n     = '0;
          state_n   = SET_DELAY;
        end else if (rise[BTN_D] && !btn_u) begin
          dec_n     = 1'b1;
          held_dn_n = 1'b1;
          rep_n     = '0;
          state_n   = SET_DELAY;
        end
      end else begin
        if (!held_lvl || (btn_u && btn_d)) begin
          state_n = SET_IDLE;
        end else if (rise[BTN_L]) begin
          clr_n = 1'b1;
        end else if (i_tick) begin
          if (rep_inc == rep_target) begin
            inc_n   = ~held_dn_q;
            dec_n   = held_dn_q;
            rep_n   = '0;
            state_n = SET_REPEAT;
          end else begin
            rep_n = rep_inc;
          end
        end
      end
    end
  end

  assign o_set_mode = (state_q != RUN);
  assign o_en       = en_q;
  assign o_inc      = inc_q;
  assign o_dec      = dec_q;
  assign o_clear    = clr_q;
  assign o_blink    = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - scoreboard bench for watch_set_ctrl against a tick-count reference model
module tb_watch_set_ctrl;

  localparam int NF = 4;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int BT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_tick = 1'b0;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic          o_set_mode, o_inc, o_dec, o_clear, o_blink;
  logic [NF-1:0] o_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_inc = 0, n_dec = 0, n_clr = 0;

  typedef struct {
    int            due;
    logic [2:0]    kind;
    logic [NF-1:0] en;
  } ev_t;
  ev_t q[$];

  // reference model: field index, absolute hold tick count, ticks since SET entry
  bit pm = 0, pn = 0, pl = 0, pu = 0, pd = 0;
  bit m_set = 0;
  int m_field = 0, m_guard = 0, m_held = 0, m_th = 0, m_st = 0;

  always #5 clk = ~clk;

  int tph = 0;
  always @(posedge clk) begin
    #1;
    i_tick = (tph == 3);
    tph = (tph + 1) % 4;
  end

  watch_set_ctrl #(
    .NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .o_set_mode(o_set_mode), .o_en(o_en), .o_inc(o_inc), .o_dec(o_dec),
    .o_clear(o_clear), .o_blink(o_blink)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pm = 0; pn = 0; pl = 0; pu = 0; pd = 0;
    m_set = 0; m_field = 0; m_guard = 0; m_held = 0; m_th = 0; m_st = 0;
  endtask

  task automatic model_step();
    bit rm, rn, rl, ru, rdn;
    logic [2:0] k;
    ev_t e;
    rm = btn_mode & !pm; rn = btn_next & !pn; rl = btn_l & !pl;
    ru = btn_u & !pu;    rdn = btn_d & !pd;
    pm = btn_mode; pn = btn_next; pl = btn_l; pu = btn_u; pd = btn_d;
    k = 3'b000;
    if (!m_set) begin
      if (rm) begin
        m_set = 1; m_field = NF - 1; m_guard = 2; m_held = 0; m_st = 0;
      end
    end else begin
      if (i_tick) m_st++;
      if (rm) begin
        m_set = 0; m_held = 0;
      end else if (rn) begin
        m_field = (m_field == 0) ? NF - 1 : m_field - 1;
        m_guard = 2; m_held = 0;
      end else if (m_guard > 0) begin
        m_guard--;
      end else if (m_held != 0) begin
        if ((m_held == 1 && !btn_u) || (m_held == 2 && !btn_d) || (btn_u && btn_d)) m_held = 0;
        else if (rl) k = 3'b100;
        else if (i_tick) begin
          m_th++;
          if (m_th == RD || (m_th > RD && (m_th - RD) % RR == 0))
            k = (m_held == 1) ? 3'b010 : 3'b001;
        end
      end else if (rl) begin
        k = 3'b100;
      end else if (ru && !btn_d) begin
        k = 3'b010; m_held = 1; m_th = 0;
      end else if (rdn && !btn_u) begin
        k = 3'b001; m_held = 2; m_th = 0;
      end
      if (k != 3'b000) begin
        e.due = cyc + 1; e.kind = k; e.en = NF'(1) << m_field;
        q.push_back(e);
      end
    end
  endtask

  task automatic model_thread();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        model_step();
        cyc++;
      end
    end
  endtask

  task automatic monitor_thread();
    logic [2:0]    pulses;
    logic [NF-1:0] e_en;
    logic          e_blink;
    ev_t           e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        continue;
      end
      e_en    = m_set ? (NF'(1) << m_field) : '0;
      e_blink = !m_set || ((m_st / BT) % 2 == 0);
      chk("mode_en_blink", {o_set_mode, o_en, o_blink}, {m_set, e_en, e_blink});
      pulses = {o_clear, o_inc, o_dec};
      n_inc += int'(o_inc); n_dec += int'(o_dec); n_clr += int'(o_clear);
      if (pulses != 3'b000 || (q.size() > 0 && q[0].due <= cyc)) begin
        if (q.size() == 0) chk("unexpected_pulse", pulses, 3'b000);
        else begin
          e = q.pop_front();
          chk("pulse_kind", pulses, e.kind);
          chk("pulse_cycle", cyc, e.due);
          chk("pulse_en", o_en, e.en);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s, s2, n;
  logic [NF-1:0] exp_en;

  initial begin
    fork
      model_thread();
      monitor_thread();
    join_none

    step(3);
    chk("rst_set_mode", o_set_mode, 0);
    chk("rst_en", o_en, 0);
    chk("rst_pulses", {o_inc, o_dec, o_clear}, 0);
    chk("rst_blink", o_blink, 1);
    rst = 1'b1;
    step(6);

    btn_mode = 1; @(negedge clk);
    chk("entry_set_mode", o_set_mode, 1);
    chk("entry_en", o_en, 4'b1000);
    chk("entry_blink", o_blink, 1);
    btn_mode = 0; step(4);

    for (int i = 0; i < 4; i++) begin
      exp_en = (i == 3) ? 4'b1000 : (4'b1000 >> (i + 1));
      btn_next = 1; @(negedge clk);
      chk("rotate_en", o_en, exp_en);
      btn_next = 0; step(3);
    end

    s = n_inc;
    btn_next = 1; @(negedge clk); btn_next = 0; btn_u = 1;
    step(3); btn_u = 0; step(3);
    chk("guard_drop_inc", n_inc - s, 0);

    s = n_inc;
    btn_next = 1; @(negedge clk); btn_next = 0; step(2);
    btn_u = 1; @(negedge clk); btn_u = 0; step(3);
    chk("guard_after_inc", n_inc - s, 1);

    s = n_inc; n = 0;
    btn_u = 1;
    while (n < 40) begin
      @(negedge clk);
      if (i_tick) n++;
    end
    @(negedge clk); btn_u = 0; step(10);
    chk("repeat_count", n_inc - s, 19);

    s = n_inc; s2 = n_dec;
    btn_u = 1; btn_d = 1; step(12); btn_u = 0; btn_d = 0; step(3);
    chk("ud_same_cycle", (n_inc - s) + (n_dec - s2), 0);

    s = n_inc; s2 = n_clr;
    btn_l = 1; btn_u = 1; @(negedge clk); btn_l = 0; btn_u = 0; step(3);
    chk("lu_clear", n_clr - s2, 1);
    chk("lu_no_inc", n_inc - s, 0);

    btn_d = 1; step(40); btn_u = 1; step(2);
    s = n_dec; s2 = n_inc; step(30);
    chk("d_then_u_dec", n_dec - s, 0);
    chk("d_then_u_inc", n_inc - s2, 0);
    btn_u = 0; btn_d = 0; step(3);

    btn_d = 1; step(40);
    btn_mode = 1; @(negedge clk);
    chk("exit_en", o_en, 0);
    chk("exit_set_mode", o_set_mode, 0);
    chk("exit_blink", o_blink, 1);
    btn_mode = 0; s = n_dec; step(20);
    chk("exit_no_dec", n_dec - s, 0);
    btn_d = 0; step(2);

    btn_mode = 1; @(negedge clk); btn_mode = 0; step(3);
    btn_u = 1; step(40);
    @(posedge clk); #2; rst = 0; #1;
    chk("arst_outputs", {o_set_mode, o_en, o_inc, o_dec, o_clear, o_blink}, 9'b0_0000_0001);
    btn_u = 0; step(2); rst = 1; step(2);

    btn_mode = 1; @(negedge clk); btn_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 29) == 0)  btn_next = ~btn_next;
      if ($urandom_range(0, 9) == 0)   btn_l = ~btn_l;
      if ($urandom_range(0, 19) == 0)  btn_u = ~btn_u;
      if ($urandom_range(0, 19) == 0)  btn_d = ~btn_d;
    end
    btn_mode = 0; btn_next = 0; btn_l = 0; btn_u = 0; btn_d = 0;
    step(10);
    chk("pending_pulses", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
